if_pc_fetch: RTL and testbench

- Fetch stage sitting directly downstream of the ID-stage branch compare.
- Consumes its Branch decision, plus jump/jr requests from the decoder, and owns the PC register.
- Drives the instruction-memory address and holds the IF/ID pipeline register (instruction, PC+4, valid).
- Honours hazard-unit stalls and squashes the wrong-path instruction on a taken redirect.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/npc_calc.sv | 43 ++++
 rtl/if_pc_fetch.sv | 79 +++++++
 tb/tb_if_pc_fetch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: reset PC, flush NOP word and the next-PC select encoding.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC select: branch/j/jr targets with priority jr > j > branch.
// Zero latency; no state, so no backpressure of its own.
module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch,
  input  logic        is_j,
  input  logic        is_jr,
  input  logic [15:0] id_imm16,
  input  logic [25:0] id_instr_index,
  input  logic [31:0] id_pc_plus4,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output npc_sel_t    npc_sel
);

  logic [31:0] br_target;
  logic [31:0] j_target;

  assign pc_plus4  = pc + 32'd4;
  assign br_target = id_pc_plus4 + {{14{id_imm16[15]}}, id_imm16, 2'b00};
  assign j_target  = {id_pc_plus4[31:28], id_instr_index, 2'b00};

  always_comb begin
    npc_sel = NPC_SEQ;
    if (is_jr)       npc_sel = NPC_JR;
    else if (is_j)   npc_sel = NPC_J;
    else if (branch) npc_sel = NPC_BR;
  end

  always_comb begin
    next_pc = pc_plus4;
    case (npc_sel)
      NPC_BR:  next_pc = br_target;
      NPC_J:   next_pc = j_target;
      NPC_JR:  next_pc = jr_target;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/if_pc_fetch.sv
// Fetch stage: PC register + IF/ID register; redirect lands on IMAddr next cycle, 1 bubble (0 with IF_DELAY_SLOT_EN).
// Stall freezes PC, IF/ID and FetchErr; a redirect seen during stall is dropped and must be re-presented.
module if_pc_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        IsJ,
  input  logic        IsJr,
  input  logic [15:0] IDImm16,
  input  logic [25:0] IDInstrIndex,
  input  logic [31:0] IDPCPlus4,
  input  logic [31:0] JrTarget,
  input  logic [31:0] IMData,
  output logic [31:0] IMAddr,
  output logic [31:0] IFIDInstr,
  output logic [31:0] IFIDPCPlus4,
  output logic        IFIDValid,
  output logic        FetchErr
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  npc_sel_t    npc_sel;
  logic        redirect;

  npc_calc u_npc_calc (
    .pc             (pc),
    .branch         (Branch),
    .is_j           (IsJ),
    .is_jr          (IsJr),
    .id_imm16       (IDImm16),
    .id_instr_index (IDInstrIndex),
    .id_pc_plus4    (IDPCPlus4),
    .jr_target      (JrTarget),
    .pc_plus4       (pc_plus4),
    .next_pc        (next_pc),
    .npc_sel        (npc_sel)
  );

  assign redirect = (npc_sel != NPC_SEQ);
  assign IMAddr   = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      IFIDInstr   <= NOP_INSTR;
      IFIDPCPlus4 <= 32'd0;
      IFIDValid   <= 1'b0;
      FetchErr    <= 1'b0;
    end else if (!Stall) begin
      pc <= next_pc;
      if (redirect && is_misaligned(next_pc)) FetchErr <= 1'b1;
`ifdef IF_DELAY_SLOT_EN
      // Delay slot: the word already fetched behind a redirect still executes.
      IFIDInstr   <= IMData;
      IFIDPCPlus4 <= pc_plus4;
      IFIDValid   <= 1'b1;
`else
      if (redirect) begin
        IFIDInstr   <= NOP_INSTR;
        IFIDPCPlus4 <= 32'd0;
        IFIDValid   <= 1'b0;
      end else begin
        IFIDInstr   <= IMData;
        IFIDPCPlus4 <= pc_plus4;
        IFIDValid   <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_if_pc_fetch.sv
// Bench for if_pc_fetch: directed scenarios plus random traffic against a cycle-level reference model.
module tb_if_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall, Branch, IsJ, IsJr;
  logic [15:0] IDImm16;
  logic [25:0] IDInstrIndex;
  logic [31:0] IDPCPlus4, JrTarget, IMData;
  logic [31:0] IMAddr, IFIDInstr, IFIDPCPlus4;
  logic        IFIDValid, FetchErr;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc, m_instr, m_pcp4;
  logic        m_valid, m_err;

  if_pc_fetch dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Branch(Branch), .IsJ(IsJ), .IsJr(IsJr),
    .IDImm16(IDImm16), .IDInstrIndex(IDInstrIndex), .IDPCPlus4(IDPCPlus4),
    .JrTarget(JrTarget), .IMData(IMData), .IMAddr(IMAddr), .IFIDInstr(IFIDInstr),
    .IFIDPCPlus4(IFIDPCPlus4), .IFIDValid(IFIDValid), .FetchErr(FetchErr)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  // Reference behaviour for one rising edge, evaluated from the inputs currently applied.
  task automatic model_edge();
    logic [31:0] tgt;
    int signed   off;
    if (Stall) return;
    if (IsJr || IsJ || Branch) begin
      off = $signed(IDImm16) * 4;
      if (IsJr)     tgt = JrTarget;
      else if (IsJ) tgt = (IDPCPlus4 & 32'hF000_0000) | (32'(IDInstrIndex) * 4);
      else          tgt = IDPCPlus4 + 32'(off);
      if (tgt % 4 != 0) m_err = 1'b1;
`ifdef IF_DELAY_SLOT_EN
      m_instr = IMData; m_pcp4 = m_pc + 4; m_valid = 1'b1;
`else
      m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
`endif
      m_pc = tgt;
    end else begin
      m_instr = IMData; m_pcp4 = m_pc + 4; m_valid = 1'b1;
      m_pc = m_pc + 4;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Stall = 0; Branch = 0; IsJ = 0; IsJr = 0;
    IDImm16 = 16'h0; IDInstrIndex = 26'h0; IDPCPlus4 = 32'h0; JrTarget = 32'h0; IMData = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    checks++;
    if (IMAddr !== 32'h3000 || IFIDValid !== 1'b0 || FetchErr !== 1'b0 || IFIDInstr !== 32'h0 || IFIDPCPlus4 !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: got addr=%h v=%b err=%b instr=%h pcp4=%h required addr=00003000 v=0 err=0 instr=0 pcp4=0",
               IMAddr, IFIDValid, FetchErr, IFIDInstr, IFIDPCPlus4);
    end
    IMData = 32'h1111_2222;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (IMAddr !== 32'h3000 || IFIDValid !== 1'b0 || FetchErr !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got addr=%h v=%b err=%b required addr=00003000 v=0 err=0", IMAddr, IFIDValid, FetchErr);
    end
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential();
    IMData = 32'h2408_0001;
    tick();
    checks++;
    if (IMAddr !== 32'h3004 || IFIDInstr !== 32'h2408_0001 || IFIDPCPlus4 !== 32'h3004 || IFIDValid !== 1'b1) begin
      failures++;
      $display("FAIL sequential: got addr=%h instr=%h pcp4=%h v=%b required addr=00003004 instr=24080001 pcp4=00003004 v=1",
               IMAddr, IFIDInstr, IFIDPCPlus4, IFIDValid);
    end
  endtask

  task automatic test_branch();
    logic [31:0] exp_instr;
    logic        exp_valid;
    IMData = 32'hDEAD_0004; Branch = 1; IDPCPlus4 = 32'h3008; IDImm16 = 16'hFFFE;
`ifdef IF_DELAY_SLOT_EN
    exp_instr = 32'hDEAD_0004; exp_valid = 1'b1;
`else
    exp_instr = 32'h0; exp_valid = 1'b0;
`endif
    tick();
    Branch = 0;
    checks++;
    if (IMAddr !== 32'h3000 || IFIDValid !== exp_valid || IFIDInstr !== exp_instr) begin
      failures++;
      $display("FAIL taken_branch: got addr=%h v=%b instr=%h required addr=00003000 v=%b instr=%h",
               IMAddr, IFIDValid, IFIDInstr, exp_valid, exp_instr);
    end
    IMData = 32'h8C00_0000;
    tick();
    checks++;
    if (IFIDInstr !== 32'h8C00_0000 || IFIDPCPlus4 !== 32'h3004 || IFIDValid !== 1'b1) begin
      failures++;
      $display("FAIL branch_target_in_ifid: got instr=%h pcp4=%h v=%b required instr=8c000000 pcp4=00003004 v=1",
               IFIDInstr, IFIDPCPlus4, IFIDValid);
    end
  endtask

  task automatic test_stall_branch();
    logic [31:0] s_pc, s_instr, s_pcp4;
    logic        s_valid;
    s_pc = IMAddr; s_instr = IFIDInstr; s_pcp4 = IFIDPCPlus4; s_valid = IFIDValid;
    Stall = 1; Branch = 1; IDPCPlus4 = 32'h3100; IDImm16 = 16'h0010; IMData = 32'hAAAA_5555;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (IMAddr !== s_pc || IFIDInstr !== s_instr || IFIDPCPlus4 !== s_pcp4 || IFIDValid !== s_valid) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got addr=%h instr=%h pcp4=%h v=%b required addr=%h instr=%h pcp4=%h v=%b",
                 i, IMAddr, IFIDInstr, IFIDPCPlus4, IFIDValid, s_pc, s_instr, s_pcp4, s_valid);
      end
    end
    Stall = 0;
    tick();
    Branch = 0;
    checks++;
    if (IMAddr !== 32'h3140) begin
      failures++;
      $display("FAIL stall_release_redirect: got addr=%h required addr=00003140", IMAddr);
    end
  endtask

  task automatic test_jump_priority();
    IsJ = 1; IDInstrIndex = 26'h0000C10; IDPCPlus4 = 32'h3010;
    tick();
    checks++;
    if (IMAddr !== 32'h0000_3040) begin
      failures++;
      $display("FAIL jump_target: got addr=%h required addr=00003040", IMAddr);
    end
    IsJr = 1; Branch = 1; JrTarget = 32'h3100; IDImm16 = 16'h0004;
    tick();
    checks++;
    if (IMAddr !== 32'h3100) begin
      failures++;
      $display("FAIL jr_priority: got addr=%h required addr=00003100", IMAddr);
    end
    IsJr = 0;
    tick();
    checks++;
    if (IMAddr !== 32'h3040) begin
      failures++;
      $display("FAIL j_over_branch: got addr=%h required addr=00003040", IMAddr);
    end
    IsJ = 0; Branch = 0;
  endtask

  task automatic test_wrap();
    IsJr = 1; JrTarget = 32'hFFFF_FFFC;
    tick();
    IsJr = 0;
    tick();
    checks++;
    if (IMAddr !== 32'h0000_0000 || FetchErr !== 1'b0) begin
      failures++;
      $display("FAIL pc_wrap: got addr=%h err=%b required addr=00000000 err=0", IMAddr, FetchErr);
    end
  endtask

  task automatic test_misaligned();
    IsJr = 1; JrTarget = 32'h3102;
    tick();
    IsJr = 0;
    checks++;
    if (IMAddr !== 32'h3102 || FetchErr !== 1'b1) begin
      failures++;
      $display("FAIL misaligned_jr: got addr=%h err=%b required addr=00003102 err=1", IMAddr, FetchErr);
    end
    repeat (5) tick();
    checks++;
    if (FetchErr !== 1'b1 || IMAddr !== 32'h3116) begin
      failures++;
      $display("FAIL fetcherr_sticky: got addr=%h err=%b required addr=00003116 err=1", IMAddr, FetchErr);
    end
    do_reset();
    checks++;
    if (FetchErr !== 1'b0) begin
      failures++;
      $display("FAIL fetcherr_clear: got err=%b required err=0", FetchErr);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      Stall = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 11);
      Branch = (r == 0) || (r == 3) || (r == 5);
      IsJ    = (r == 1) || (r == 3) || (r == 4);
      IsJr   = (r == 2) || (r == 3) || (r == 4) || (r == 5);
      IDImm16      = 16'($urandom);
      IDInstrIndex = 26'($urandom);
      IDPCPlus4    = $urandom & 32'hFFFF_FFFC;
      JrTarget     = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      IMData       = $urandom;
      tick();
      checks++;
      if ({IMAddr, IFIDInstr, IFIDPCPlus4, IFIDValid, FetchErr} !== {m_pc, m_instr, m_pcp4, m_valid, m_err}) begin
        failures++;
        $display("FAIL random[%0d]: got addr=%h instr=%h pcp4=%h v=%b err=%b required addr=%h instr=%h pcp4=%h v=%b err=%b",
                 i, IMAddr, IFIDInstr, IFIDPCPlus4, IFIDValid, FetchErr, m_pc, m_instr, m_pcp4, m_valid, m_err);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    test_reset();
    test_sequential();
    test_branch();
    test_stall_branch();
    test_jump_priority();
    test_wrap();
    test_misaligned();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
